// File: rtl/bsg_link_ct_reset_sequencer_pkg.sv
// Shared types for the link/channel-tunnel reset sequencer.
//   bsg_link_ct_state_e  : sequencer FSM states
//   bsg_link_ct_resets_s : the seven reset bits, ordered token, up_io, down_io,
//                          up_core, down_core, ct, fifo (tag payload order)
//   state_resets()       : reset bit pattern driven while in a given state
package bsg_link_ct_seq_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ASSERT   = 4'd1,
    TOKEN_HI = 4'd2,
    TOKEN_LO = 4'd3,
    UP_IO    = 4'd4,
    DOWN_IO  = 4'd5,
    CORE     = 4'd6,
    CT       = 4'd7,
    DONE     = 4'd8
  } bsg_link_ct_state_e;

  typedef struct packed {
    logic token;
    logic up_io;
    logic down_io;
    logic up_core;
    logic down_core;
    logic ct;
    logic fifo;
  } bsg_link_ct_resets_s;

  // Everything held in reset, no token pulse.
  localparam bsg_link_ct_resets_s resets_held_lp = 7'b0111111;

  // Releases accumulate as the FSM advances, so each bit is simply "has the
  // sequence reached the step that frees it yet".
  function automatic bsg_link_ct_resets_s state_resets(input bsg_link_ct_state_e st);
    bsg_link_ct_resets_s r;
    r           = resets_held_lp;
    r.token     = (st == TOKEN_HI);
    r.up_io     = !(st inside {UP_IO, DOWN_IO, CORE, CT, DONE});
    r.down_io   = !(st inside {DOWN_IO, CORE, CT, DONE});
    r.up_core   = !(st inside {CORE, CT, DONE});
    r.down_core = r.up_core;
    r.ct        = !(st inside {CT, DONE});
    r.fifo      = r.ct;
    return r;
  endfunction

endpackage

// File: rtl/bsg_link_ct_reset_sequencer_if.sv
// Request/reset bundle between the sequencer and the link/tunnel wrapper.
//   start_i, hold_cycles_i : sequence request and per-step hold length
//   *_reset_o              : reset bits consumed by the wrapper
//   busy_o, done_o         : sequence status
// master = sequencer side, slave = requester/consumer side.
interface bsg_link_ct_reset_sequencer_if #(parameter int wait_width_p = 8);

  logic                    start_i;
  logic [wait_width_p-1:0] hold_cycles_i;
  logic                    async_token_reset_o;
  logic                    up_io_reset_o;
  logic                    down_io_reset_o;
  logic                    up_core_reset_o;
  logic                    down_core_reset_o;
  logic                    ct_reset_o;
  logic                    fifo_reset_o;
  logic                    busy_o;
  logic                    done_o;

  modport master (
    input  start_i, hold_cycles_i,
    output async_token_reset_o, up_io_reset_o, down_io_reset_o,
           up_core_reset_o, down_core_reset_o, ct_reset_o, fifo_reset_o,
           busy_o, done_o
  );

  modport slave (
    output start_i, hold_cycles_i,
    input  async_token_reset_o, up_io_reset_o, down_io_reset_o,
           up_core_reset_o, down_core_reset_o, ct_reset_o, fifo_reset_o,
           busy_o, done_o
  );

endinterface

// File: rtl/bsg_link_ct_reset_sequencer_timer.sv
// Per-step hold counter for the reset sequencer.
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   load_i           : restart counting from zero
//   limit_i          : terminal count value
//   terminal_o       : count has reached limit_i
module bsg_link_ct_seq_timer #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               load_i,
  input  logic [width_p-1:0] limit_i,
  output logic               terminal_o
);

  logic [width_p-1:0] count_q, count_d;

  // Next count: restart on load, otherwise increment.
  always_comb begin
    count_d = count_q + {{(width_p-1){1'b0}}, 1'b1};
    if (load_i) begin
      count_d = '0;
    end else begin
      count_d = count_q + {{(width_p-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_o = (count_q == limit_i);

endmodule

// File: rtl/bsg_link_ct_reset_sequencer.sv
// Orders the reset release of one DDR IO link plus channel-tunnel endpoint:
// hold all, pulse the async token reset, then release up IO, down IO, both
// core links, and finally tunnel + hop FIFO.
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   link_if (master) : start/hold request in, reset bits and busy/done out
// All outputs are registered; outputs in a cycle reflect the state held in it.
module bsg_link_ct_reset_sequencer
  import bsg_link_ct_seq_pkg::*;
#(
  parameter int wait_width_p         = 8,
  parameter int token_pulse_cycles_p = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  bsg_link_ct_reset_sequencer_if.master link_if
);

  localparam logic [wait_width_p-1:0] one_lp        = wait_width_p'(1);
  localparam logic [wait_width_p-1:0] token_last_lp = wait_width_p'(token_pulse_cycles_p - 1);

  bsg_link_ct_state_e      state_q, state_d;
  logic [wait_width_p-1:0] hold_q, hold_d;
  bsg_link_ct_resets_s     resets_q, resets_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [wait_width_p-1:0] limit;
  logic                    timer_load;
  logic                    terminal;

  bsg_link_ct_seq_timer #(.width_p(wait_width_p)) timer (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load_i     (timer_load),
    .limit_i    (limit),
    .terminal_o (terminal)
  );

  // Next-state, step limit and next registered outputs.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    limit   = hold_q - one_lp;
    case (state_q)
      IDLE, DONE: begin
        if (link_if.start_i) begin
          state_d = ASSERT;
          hold_d  = (link_if.hold_cycles_i == '0) ? one_lp : link_if.hold_cycles_i;
        end else begin
          state_d = state_q;
        end
      end
      ASSERT: begin
        // ASSERT absorbs the start-acceptance cycle, so it runs one cycle
        // longer than the other timed steps (terminal at hold, not hold-1).
        limit = hold_q;
        if (terminal) state_d = TOKEN_HI;
        else          state_d = state_q;
      end
      TOKEN_HI: begin
        limit = token_last_lp;
        if (terminal) state_d = TOKEN_LO;
        else          state_d = state_q;
      end
      TOKEN_LO: begin
        if (terminal) state_d = UP_IO;
        else          state_d = state_q;
      end
      UP_IO: begin
        if (terminal) state_d = DOWN_IO;
        else          state_d = state_q;
      end
      DOWN_IO: begin
        if (terminal) state_d = CORE;
        else          state_d = state_q;
      end
      CORE: begin
        if (terminal) state_d = CT;
        else          state_d = state_q;
      end
      CT: begin
        if (terminal) state_d = DONE;
        else          state_d = state_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Keep the counter parked at zero while waiting and restart it on every
    // step change, so each step sees a fresh count from its first cycle.
    timer_load = (state_d != state_q) || (state_q == IDLE) || (state_q == DONE);

    resets_d = state_resets(state_d);
    busy_d   = !(state_d inside {IDLE, DONE});
    done_d   = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      hold_q   <= one_lp;
      resets_q <= resets_held_lp;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      resets_q <= resets_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign link_if.async_token_reset_o = resets_q.token;
  assign link_if.up_io_reset_o       = resets_q.up_io;
  assign link_if.down_io_reset_o     = resets_q.down_io;
  assign link_if.up_core_reset_o     = resets_q.up_core;
  assign link_if.down_core_reset_o   = resets_q.down_core;
  assign link_if.ct_reset_o          = resets_q.ct;
  assign link_if.fifo_reset_o        = resets_q.fifo;
  assign link_if.busy_o              = busy_q;
  assign link_if.done_o              = done_q;

endmodule

// File: tb/tb_bsg_link_ct_reset_sequencer.sv
// Directed bench for the link/tunnel reset sequencer. Cycle c is the state
// seen just after clock edge c, with the start request sampled at edge 1.
module tb_bsg_link_ct_reset_sequencer;

  localparam int W = 8;
  localparam int T = 4;
  // {token, up_io, down_io, up_core, down_core, ct, fifo, busy, done}
  localparam logic [8:0] IDLE_V = 9'b0_111111_0_0;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [8:0] obs_v;

  bsg_link_ct_reset_sequencer_if #(.wait_width_p(W)) link_if ();

  bsg_link_ct_reset_sequencer #(
    .wait_width_p         (W),
    .token_pulse_cycles_p (T)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .link_if   (link_if)
  );

  always #5 clk = ~clk;

  assign obs_v = {link_if.async_token_reset_o, link_if.up_io_reset_o,
                  link_if.down_io_reset_o, link_if.up_core_reset_o,
                  link_if.down_core_reset_o, link_if.ct_reset_o,
                  link_if.fifo_reset_o, link_if.busy_o, link_if.done_o};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected outputs at cycle c of a sequence with hold n (n >= 1).
  function automatic logic [8:0] exp_vec(input int c, input int n);
    int d;
    logic [8:0] v;
    d    = 2 + 6*n + T;
    v[8] = (c >= n + 2) && (c <= n + 1 + T);
    v[7] = (c < 2*n + 2 + T);
    v[6] = (c < 3*n + 2 + T);
    v[5] = (c < 4*n + 2 + T);
    v[4] = (c < 4*n + 2 + T);
    v[3] = (c < 5*n + 2 + T);
    v[2] = (c < 5*n + 2 + T);
    v[1] = (c >= 1) && (c < d);
    v[0] = (c >= d);
    return v;
  endfunction

  function automatic bit inv_ok(input logic [8:0] v, input logic [5:0] prev);
    bit ok;
    ok = 1'b1;
    if (v[8] && !(v[7] && v[6]))                 ok = 1'b0;
    if ((!v[5] || !v[4]) && (v[7] || v[6]))      ok = 1'b0;
    if ((!v[3] || !v[2]) && (v[5] || v[4]))      ok = 1'b0;
    if (v[1] && v[0])                            ok = 1'b0;
    if ((~prev & v[7:2]) != 6'b0)                ok = 1'b0;
    return ok;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start; returns positioned at cycle 1.
  task automatic start_seq(input int hold);
    link_if.hold_cycles_i = W'(hold);
    link_if.start_i       = 1'b1;
    step();
    link_if.start_i       = 1'b0;
  endtask

  // Check cycles c_from..c_to, ending positioned at c_to.
  task automatic check_span(input string tag, input int n, input int c_from, input int c_to);
    for (int c = c_from; c <= c_to; c++) begin
      check_val($sformatf("%s_c%0d", tag, c), 32'(obs_v), 32'(exp_vec(c, n)));
      if (c < c_to) step();
    end
  endtask

  initial begin
    reset_n               = 1'b0;
    link_if.start_i       = 1'b0;
    link_if.hold_cycles_i = '0;

    // Power-on
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("por_rst", 32'(obs_v), 32'(IDLE_V));
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("por_idle", 32'(obs_v), 32'(IDLE_V));
    end

    // Nominal hold=3: token 5-8, up_io 12, down_io 15, core 18, ct 21, done 24
    start_seq(3);
    check_span("nom", 3, 1, 27);

    // hold=0 behaves as 1: done at cycle 12
    step();
    start_seq(0);
    check_span("hold0", 1, 1, 14);

    // start held high: one sequence, then restart right after done
    step();
    link_if.hold_cycles_i = W'(2);
    link_if.start_i       = 1'b1;
    step();
    check_span("held", 2, 1, 18);
    step();
    check_val("held_restart", 32'(obs_v), 32'(exp_vec(1, 2)));
    link_if.start_i = 1'b0;
    step();
    check_span("held2", 2, 2, 20);

    // reset during CORE (cycles 18-20 for hold=3)
    step();
    start_seq(3);
    check_span("pre_rst", 3, 1, 19);
    reset_n = 1'b0;
    step();
    check_val("mid_rst", 32'(obs_v), 32'(IDLE_V));
    reset_n = 1'b1;
    step();
    check_val("post_rst_idle", 32'(obs_v), 32'(IDLE_V));
    step();
    start_seq(3);
    check_span("after_rst", 3, 1, 25);

    // Random holds, including the maximum
    for (int s = 0; s < 20; s++) begin
      int hold;
      int bad;
      int lat;
      int d;
      logic [5:0] prev;
      hold = (s == 0) ? 255 : int'($urandom_range(1, 255));
      d    = 2 + 6*hold + T;
      bad  = 0;
      lat  = -1;
      prev = 6'h3f;
      step();
      start_seq(hold);
      for (int c = 1; c <= d + 2; c++) begin
        if (obs_v !== exp_vec(c, hold)) bad++;
        if (!inv_ok(obs_v, prev))       bad++;
        prev = obs_v[7:2];
        if (obs_v[0] === 1'b1 && lat < 0) lat = c - 1;
        if (c < d + 2) step();
      end
      check_val($sformatf("rand_bad_h%0d", hold), 32'(bad), 32'(0));
      check_val($sformatf("rand_lat_h%0d", hold), 32'(lat), 32'(1 + 6*hold + T));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
